// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state encoding and port indices for
// the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic P_IFETCH = 1'b0;
  localparam logic P_DATA   = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the arbiter.
// slave  = the arbiter itself, master = requesters plus memory model.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              p0_req, p1_req;
  logic              p0_we, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_ack, p1_ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_we;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
    input  p0_wdata, p1_wdata, mem_data_out,
    output p0_ack, p1_ack, rdata, err, busy, mem_addr, mem_data_in, mem_we
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
    output p0_wdata, p1_wdata, mem_data_out,
    input  p0_ack, p1_ack, rdata, err, busy, mem_addr, mem_data_in, mem_we
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick. On a tie the port that was not
// served last wins; grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // pick a single winner from the request pair
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (ifetch/data) round-robin memory arbiter.
// One access per IDLE -> BUSY -> DONE pass; memory strobed in BUSY, ack in DONE.
// Optional build macro MEM_ARBITER_ALIGN_CHK_EN: even (incl. zero) addresses
// are rejected with err=1 and never reach memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_t            state, state_nx;
  logic              ptr;        // port favoured on the next tie
  logic              win;        // port owning the current/last access
  logic              just_done;  // high in the IDLE cycle right after DONE
  logic              lat_we, lat_bad;
  logic              last_srv;
  logic [1:0]        req_m, grant;
  logic              pick_we, pick_bad;
  logic [ADDR_W-1:0] pick_addr, addr_q;
  logic [DATA_W-1:0] pick_wdata, wdata_q, rdata_q;
  logic              we_q;

  // mask the port just served so the other one gets a turn
  always_comb begin
    req_m = {bus.p1_req, bus.p0_req};
    if (just_done) req_m[win] = 1'b0;
  end

  assign last_srv = ~ptr;

  rr_arb2 u_rr (
    .req  (req_m),
    .last (last_srv),
    .grant(grant)
  );

  // route the winner's request fields and classify the address
  always_comb begin
    pick_we    = grant[1] ? bus.p1_we    : bus.p0_we;
    pick_addr  = grant[1] ? bus.p1_addr  : bus.p0_addr;
    pick_wdata = grant[1] ? bus.p1_wdata : bus.p0_wdata;
`ifdef MEM_ARBITER_ALIGN_CHK_EN
    pick_bad   = ~pick_addr[0];
`else
    pick_bad   = 1'b0;
`endif
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state: fixed three-cycle walk once a grant happens
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|grant) state_nx = BUSY;
      BUSY:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // request latch, memory strobe, read capture and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= P_IFETCH;
      win       <= P_IFETCH;
      just_done <= 1'b0;
      lat_we    <= 1'b0;
      lat_bad   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      just_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (|grant) begin
            win     <= grant[1];
            lat_we  <= pick_we;
            lat_bad <= pick_bad;
            if (!pick_bad) begin
              addr_q  <= pick_addr;
              wdata_q <= pick_wdata;
              we_q    <= pick_we;
            end
          end
        end
        BUSY: begin
          we_q <= 1'b0;
          if (!lat_we && !lat_bad) rdata_q <= bus.mem_data_out;
        end
        DONE:    ptr <= ~win;
        default: ;
      endcase
    end
  end

  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.p0_ack      = (state == DONE) && (win == P_IFETCH);
  assign bus.p1_ack      = (state == DONE) && (win == P_DATA);
  assign bus.err         = (state == DONE) && lat_bad;
  assign bus.busy        = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, byte address width.
REQ-002 SHALL have parameter DATA_W, default 16, word width.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: p0_req/p1_req  in  1 each  access request, port 0 = instruction fetch, port 1 = data.
REQ-006 SHALL have ports: p0_we/p1_we  in  1 each  write enable of request.
REQ-007 SHALL have ports: p0_addr/p1_addr  in  ADDR_W each  word address, high byte at addr, low byte at addr-1.
REQ-008 SHALL have ports: p0_wdata/p1_wdata  in  DATA_W each  write data.
REQ-009 SHALL have ports: p0_ack/p1_ack  out  1 each  one-cycle completion pulse.
REQ-010 SHALL have ports: rdata  out  DATA_W  read data, valid only while an ack is high.
REQ-011 SHALL have ports: err  out  1  access rejected, valid only while an ack is high.
REQ-012 SHALL have ports: busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have ports: mem_addr  out  ADDR_W, mem_data_in  out  DATA_W, mem_we  out  1, mem_data_out  in  DATA_W  (memory side).

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-015 IDLE: if any unmasked req is high, pick a winner, latch its we/addr/wdata, and go to BUSY; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin, 2-way: on a tie, grant the port not served last; the pointer resets to favour port 0.
REQ-017 BUSY: drive mem_addr/mem_data_in from the latch, and mem_we = latched we for exactly this one cycle; capture mem_data_out into rdata at the cycle end when reading.
REQ-018 DONE: pulse the winner's ack for one cycle with rdata/err; update the pointer; mem_we = 0.
REQ-019 Latency SHALL be exactly 3 cycles, counted from the edge sampling req to the edge after the ack cycle; there SHALL be one access per 3 cycles maximum.
REQ-020 A requester SHALL hold req/we/addr/wdata stable until ack; the port just served SHALL be masked in the IDLE cycle following DONE.
REQ-021 mem_we SHALL be low in IDLE and DONE; mem_addr holds its last value outside BUSY.
REQ-022 rdata SHALL hold its value on writes; on a write ack its content is don't-care.
REQ-023 A req dropped before ack while in BUSY/DONE SHALL NOT abort the access; the access completes and acks.

Reset
REQ-024 rst SHALL asynchronously force state=IDLE, pointer=port 0, acks=0, err=0, mem_we=0, busy=0, rdata=0, mem_addr=0, mem_data_in=0.
REQ-025 Reset during BUSY SHALL drop mem_we immediately and produce no ack; write completion is undefined.

Configuration
REQ-026 Macro MEM_ARBITER_ALIGN_CHK_EN defined: a latched address that is even, or equals 0, SHALL skip BUSY memory activity (mem_we stays 0) and ack in DONE with err=1; latency is unchanged.
REQ-027 Macro absent: no check is performed; err is tied to 0; all addresses pass through to memory.

Structure
REQ-028 Package mem_arbiter_pkg SHALL hold ADDR_W/DATA_W defaults, the state enum (IDLE, BUSY, DONE), and port index constants P_IFETCH=0 and P_DATA=1.
REQ-029 The round-robin pick SHALL be the sub-module rr_arb2 (inputs: req[1:0], last; output: grant[1:0], one-hot or zero).

Verification
REQ-030 Port 1 writes 16'hBEEF at 14'h0011, then port 0 reads 14'h0011 -> mem_we high exactly 1 cycle; p0_ack with rdata=16'hBEEF 3 cycles after req.
REQ-031 p0_req and p1_req held high continuously after reset -> acks alternate p0, p1, p0, p1, spaced 3 cycles.
REQ-032 rst asserted mid-BUSY of a write -> mem_we, busy and acks drop asynchronously; no ack follows; the next grant goes to port 0.
REQ-033 p1_req drops in BUSY -> p1_ack is still issued in DONE.
REQ-034 With MEM_ARBITER_ALIGN_CHK_EN, a write to 14'h0010 -> mem_we never high, p1_ack with err=1; without the macro -> normal write, err=0.
